mem_access: RTL
===============

// Module: mem_access
// PURPOSE
//  MEM stage: sits between the EX/MEM and MEM/WB pipeline registers. Non-memory ops pass through combinationally.
//  Loads/stores run a multi-cycle valid/ready transaction on the data-memory port.
//  stall_req freezes earlier stages until the access completes.
//  Handles byte-lane steering, load sign/zero extension and misaligned-access detection.
// PARAMETERS
//  ADDR_W   32  data-memory byte-address width
//  DATA_W   32  data width; fixed at 32 for byte-lane logic
// PORTS
//  CLK          in   1             clock, rising edge
//  RST          in   1             asynchronous reset, active-high
//  hold         in   1             downstream freeze (stall[4]); keeps a finished access parked in DONE
//  mem_rd       in   5             destination register from EX/MEM
//  mem_rd_op    in   1             register-write enable from EX/MEM
//  mem_rd_data  in   32            ALU result from EX/MEM
//  mem_aluop    in   ALU_OP_WIDTH  op code (config.vh `ALU_* codes)
//  mem_mem_addr in   32            effective byte address
//  mem_mem_wdata in  32            store data, low-aligned
//  dm_req_valid out  1             memory request valid
//  dm_req_ready in   1             memory accepts request
//  dm_we        out  1             1 = store
//  dm_be        out  4             byte enables
//  dm_addr      out  32            word address {addr[31:2],2'b00}
//  dm_wdata     out  32            lane-replicated store data
//  dm_rsp_valid in   1             load data valid
//  dm_rsp_data  in   32            load word
//  wb_rd        out  5             to MEM/WB
//  wb_rd_op     out  1             to MEM/WB
//  wb_rd_data   out  32            to MEM/WB
//  stall_req    out  1             to stall controller
//  misalign     out  1             misaligned-access flag, one per offending op
// BEHAVIOUR
//  - Memory ops: LB LH LW LBU LHU SB SH SW. All other aluops are non-memory.
//  - Non-memory ops: wb_* = mem_* same cycle; stall_req=0; dm_req_valid=0.
//  - Misaligned access: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
//    misalign=1, no request issued, wb_rd_op=0, stall_req=0.
//  - FSM states: IDLE, REQ, WAIT, DONE. All state is cleared by RST.
//    IDLE: on an aligned memory op -> REQ.
//    REQ: dm_req_valid=1; dm_* stable until accepted. On dm_req_ready: store -> DONE, load -> WAIT.
//    WAIT: on dm_rsp_valid, capture the extended load data -> DONE.
//    DONE: if hold=1 stay in DONE; otherwise -> IDLE.
//  - stall_req=1 for an aligned memory op while the FSM is in IDLE, REQ or WAIT; 0 in DONE.
//    wb_rd_op=0 while stall_req=1.
//  - Result in DONE: load gives wb_rd_op=mem_rd_op and wb_rd_data=captured data. Store gives wb_rd_op=0.
//  - Minimum latency with ready=1 and rsp on the next cycle: load 4 cycles (IDLE, REQ, WAIT, DONE). Store 3 cycles.
//  - Store lanes:
//    SB: be=1<<addr[1:0], wdata={4{b}}.
//    SH: be=addr[1]?4'b1100:4'b0011, wdata={2{h}}.
//    SW: be=4'b1111.
//  - Loads: be=4'b1111, we=0. Byte/half selected by the captured addr[1:0].
//    LB/LH sign-extend; LBU/LHU zero-extend.
//  - dm_rsp_valid outside WAIT is ignored, including stale responses after reset.
//  - RST (any time, including mid-transaction): FSM -> IDLE. While RST is high, every output is 0.
//    The aborted access is never re-reported.
// TESTING
//  - ADD: rd=5, data=0x1234 -> wb same cycle, stall_req=0, dm_req_valid=0.
//  - LB addr=0x103, rsp=0x80FF_FF_FF, ready=1 -> stall 3 cycles; DONE wb_rd_data=0xFFFFFF80.
//  - Same load as LBU -> wb_rd_data=0x00000080.
//  - SH addr=0x102, wdata=0xABCD, ready low 2 cycles -> dm_req_valid held with be=1100, wdata=0xABCDABCD.
//    Store completes; wb_rd_op=0.
//  - LW addr=0x101 -> misalign=1, no request, stall_req=0, wb_rd_op=0.
//  - LW with RST asserted in WAIT -> all outputs 0. A later dm_rsp_valid is ignored; the next ADD passes through normally.

Source files
------------

// File: rtl/mem_access.sv
// MEM pipeline stage: passes non-memory ops straight through and runs a
// valid/ready data-memory transaction (with lane steering and load extension) for loads/stores.
module mem_access #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned ALU_OP_WIDTH = 5
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    hold,
  input  logic [4:0]              mem_rd,
  input  logic                    mem_rd_op,
  input  logic [DATA_W-1:0]       mem_rd_data,
  input  logic [ALU_OP_WIDTH-1:0] mem_aluop,
  input  logic [ADDR_W-1:0]       mem_mem_addr,
  input  logic [DATA_W-1:0]       mem_mem_wdata,
  output logic                    dm_req_valid,
  input  logic                    dm_req_ready,
  output logic                    dm_we,
  output logic [3:0]              dm_be,
  output logic [ADDR_W-1:0]       dm_addr,
  output logic [DATA_W-1:0]       dm_wdata,
  input  logic                    dm_rsp_valid,
  input  logic [DATA_W-1:0]       dm_rsp_data,
  output logic [4:0]              wb_rd,
  output logic                    wb_rd_op,
  output logic [DATA_W-1:0]       wb_rd_data,
  output logic                    stall_req,
  output logic                    misalign
);

  localparam logic [ALU_OP_WIDTH-1:0] ALU_LB  = ALU_OP_WIDTH'(16);
  localparam logic [ALU_OP_WIDTH-1:0] ALU_LH  = ALU_OP_WIDTH'(17);
  localparam logic [ALU_OP_WIDTH-1:0] ALU_LW  = ALU_OP_WIDTH'(18);
  localparam logic [ALU_OP_WIDTH-1:0] ALU_LBU = ALU_OP_WIDTH'(19);
  localparam logic [ALU_OP_WIDTH-1:0] ALU_LHU = ALU_OP_WIDTH'(20);
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SB  = ALU_OP_WIDTH'(21);
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SH  = ALU_OP_WIDTH'(22);
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SW  = ALU_OP_WIDTH'(23);

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t              state;
  logic                is_load;
  logic                is_store;
  logic                is_mem;
  logic                is_signed;
  logic [1:0]          size;
  logic                mis;
  logic [3:0]          be_c;
  logic [DATA_W-1:0]   wdata_c;

  logic                cap_load;
  logic                cap_signed;
  logic [1:0]          cap_size;
  logic [1:0]          cap_off;
  logic [DATA_W-1:0]   ld_data;

  // Op decode and alignment check
  always_comb begin
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_signed = 1'b0;
    size      = SZ_WORD;
    case (mem_aluop)
      ALU_LB:  begin is_load = 1'b1; is_signed = 1'b1; size = SZ_BYTE; end
      ALU_LH:  begin is_load = 1'b1; is_signed = 1'b1; size = SZ_HALF; end
      ALU_LW:  begin is_load = 1'b1; size = SZ_WORD; end
      ALU_LBU: begin is_load = 1'b1; size = SZ_BYTE; end
      ALU_LHU: begin is_load = 1'b1; size = SZ_HALF; end
      ALU_SB:  begin is_store = 1'b1; size = SZ_BYTE; end
      ALU_SH:  begin is_store = 1'b1; size = SZ_HALF; end
      ALU_SW:  begin is_store = 1'b1; size = SZ_WORD; end
      default: ;
    endcase
    is_mem = is_load | is_store;
    mis    = ((size == SZ_HALF) && mem_mem_addr[0]) ||
             ((size == SZ_WORD) && (mem_mem_addr[1:0] != 2'b00));
  end

  // Store lane steering; loads always request the full word
  always_comb begin
    be_c    = 4'b1111;
    wdata_c = mem_mem_wdata;
    if (is_store) begin
      case (size)
        SZ_BYTE: begin
          be_c    = 4'b0001 << mem_mem_addr[1:0];
          wdata_c = {4{mem_mem_wdata[7:0]}};
        end
        SZ_HALF: begin
          be_c    = mem_mem_addr[1] ? 4'b1100 : 4'b0011;
          wdata_c = {2{mem_mem_wdata[15:0]}};
        end
        default: ;
      endcase
    end
  end

  function automatic logic [DATA_W-1:0] extend_load(input logic [DATA_W-1:0] word,
                                                    input logic [1:0] off,
                                                    input logic [1:0] sz,
                                                    input logic sgn);
    logic [DATA_W-1:0] sh;
    sh = word >> {off, 3'b000};
    case (sz)
      SZ_BYTE: extend_load = sgn ? {{24{sh[7]}}, sh[7:0]} : {24'b0, sh[7:0]};
      SZ_HALF: extend_load = sgn ? {{16{sh[15]}}, sh[15:0]} : {16'b0, sh[15:0]};
      default: extend_load = word;
    endcase
  endfunction

  // Transaction FSM with registered memory-port outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state        <= S_IDLE;
      dm_req_valid <= 1'b0;
      dm_we        <= 1'b0;
      dm_be        <= 4'b0;
      dm_addr      <= '0;
      dm_wdata     <= '0;
      cap_load     <= 1'b0;
      cap_signed   <= 1'b0;
      cap_size     <= 2'b0;
      cap_off      <= 2'b0;
      ld_data      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (is_mem && !mis) begin
            state        <= S_REQ;
            dm_req_valid <= 1'b1;
            dm_we        <= is_store;
            dm_be        <= be_c;
            dm_addr      <= {mem_mem_addr[ADDR_W-1:2], 2'b00};
            dm_wdata     <= wdata_c;
            cap_load     <= is_load;
            cap_signed   <= is_signed;
            cap_size     <= size;
            cap_off      <= mem_mem_addr[1:0];
          end
        end
        S_REQ: begin
          if (dm_req_ready) begin
            dm_req_valid <= 1'b0;
            state        <= cap_load ? S_WAIT : S_DONE;
          end
        end
        S_WAIT: begin
          if (dm_rsp_valid) begin
            ld_data <= extend_load(dm_rsp_data, cap_off, cap_size, cap_signed);
            state   <= S_DONE;
          end
        end
        S_DONE: begin
          if (!hold) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Writeback/stall outputs are combinational so non-memory ops pass in the same cycle
  always_comb begin
    wb_rd      = 5'b0;
    wb_rd_op   = 1'b0;
    wb_rd_data = '0;
    stall_req  = 1'b0;
    misalign   = 1'b0;
    if (!RST) begin
      wb_rd      = mem_rd;
      wb_rd_op   = mem_rd_op;
      wb_rd_data = mem_rd_data;
      case (state)
        S_IDLE: begin
          if (is_mem) begin
            wb_rd_op = 1'b0;
            if (mis) misalign = 1'b1;
            else     stall_req = 1'b1;
          end
        end
        S_REQ, S_WAIT: begin
          stall_req = 1'b1;
          wb_rd_op  = 1'b0;
        end
        S_DONE: begin
          if (cap_load) wb_rd_data = ld_data;
          else          wb_rd_op   = 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
